// File: rtl/demux8_reg_pkg.sv
// Shared constants, slot-index type and bit helpers for the 8-way
// registered write-side distributor.
package demux8_reg_pkg;

    localparam int SLOTS = 8;
    localparam int SEL_W = 3;
    localparam int CNT_W = 4;

    typedef logic [SEL_W-1:0] slot_idx_t;

    function automatic logic [SLOTS-1:0] onehot(input slot_idx_t idx);
        logic [SLOTS-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [SLOTS-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < SLOTS; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/demux8_slot.sv
// One output slot: a data register plus an occupancy bit.
// Load wins over ack so a same-cycle refill keeps the slot occupied.
module demux8_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             ack,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             valid
);

    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] data_next;
    logic             valid_reg;
    logic             valid_next;

    always_comb begin
        data_next  = load ? d : data_reg;
        valid_next = load | (valid_reg & ~ack);
    end

    // Consumed data is retained; only the valid bit drops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            data_reg  <= data_next;
            valid_reg <= valid_next;
        end
    end

    assign q     = data_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/demux8_reg.sv
// Registered 1-to-8 distributor: latches E into slot sel, holds it until
// acked, and tracks occupancy and a sticky overrun flag.
module demux8_reg
    import demux8_reg_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [SEL_W-1:0] sel,
    input  logic [WIDTH-1:0] E,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SLOTS-1:0] ack,
    output logic [WIDTH-1:0] S0,
    output logic [WIDTH-1:0] S1,
    output logic [WIDTH-1:0] S2,
    output logic [WIDTH-1:0] S3,
    output logic [WIDTH-1:0] S4,
    output logic [WIDTH-1:0] S5,
    output logic [WIDTH-1:0] S6,
    output logic [WIDTH-1:0] S7,
    output logic [SLOTS-1:0] S_valid,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             overrun
);

    logic [WIDTH-1:0] slot_data [SLOTS];
    logic [SLOTS-1:0] slot_valid;
    logic [SLOTS-1:0] load_vec;
    logic [SLOTS-1:0] pop_vec;
    logic             write;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             overrun_reg;
    logic             overrun_next;

    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
            demux8_slot #(.WIDTH(WIDTH)) u_slot (
                .clk     (clk),
                .reset_n (reset_n),
                .load    (load_vec[gi]),
                .ack     (ack[gi]),
                .d       (E),
                .q       (slot_data[gi]),
                .valid   (slot_valid[gi])
            );
        end
    endgenerate

    // A slot being acked this cycle can be refilled in the same cycle.
    always_comb begin
        in_ready     = ~slot_valid[sel] | ack[sel];
        write        = in_valid & in_ready;
        load_vec     = onehot(sel) & {SLOTS{write}};
        pop_vec      = ack & slot_valid;
        count_next   = count_reg + CNT_W'(write) - popcount(pop_vec);
        overrun_next = overrun_reg | (in_valid & ~in_ready);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg   <= '0;
            overrun_reg <= 1'b0;
        end else begin
            count_reg   <= count_next;
            overrun_reg <= overrun_next;
        end
    end

    assign S0      = slot_data[0];
    assign S1      = slot_data[1];
    assign S2      = slot_data[2];
    assign S3      = slot_data[3];
    assign S4      = slot_data[4];
    assign S5      = slot_data[5];
    assign S6      = slot_data[6];
    assign S7      = slot_data[7];
    assign S_valid = slot_valid;
    assign count   = count_reg;
    assign full    = (count_reg == CNT_W'(SLOTS));
    assign overrun = overrun_reg;

endmodule
